// File: rtl/taxi_ram_arb_pkg.sv
// Shared helpers for the 1R1W RAM arbiter: round-robin grant search and pointer sizing.
package taxi_ram_arb_pkg;

  localparam int unsigned MaxPorts = 16;
  localparam int unsigned MaxPtrW  = 4;

  // Pointer width for a given port count, never narrower than one bit.
  function automatic int unsigned cl_ports(input int unsigned ports);
    return (ports > 1) ? $clog2(ports) : 1;
  endfunction

  // One-hot grant of the first set mask bit at or after ptr. Unused upper mask
  // bits are zero, so wrapping modulo MaxPorts equals wrapping modulo PORTS.
  function automatic logic [MaxPorts-1:0] rr_next(input logic [MaxPorts-1:0] mask,
                                                 input logic [MaxPtrW-1:0]  ptr);
    logic [MaxPorts-1:0] grant;
    logic [MaxPtrW-1:0]  idx;
    grant = '0;
    for (int unsigned i = 0; i < MaxPorts; i++) begin
      idx = ptr + MaxPtrW'(i);
      if (mask[idx] && (grant == '0)) begin
        grant[idx] = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/taxi_ram_1r1w_dc.sv
// Simple dual-port RAM primitive: one write port with optional byte strobes and
// one registered read port, each on its own clock. Contents are never reset.
module taxi_ram_1r1w_dc #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter logic        STRB_EN = 1'b1,
  parameter int unsigned STRB_W  = DATA_W / 8
) (
  input  logic              wr_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [STRB_W-1:0] wr_strb,
  input  logic              rd_clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned LaneW = DATA_W / STRB_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (!STRB_EN || wr_strb[i]) begin
          mem[wr_addr][i*LaneW +: LaneW] <= wr_data[i*LaneW +: LaneW];
        end
      end
    end
  end

  // Output register holds its value whenever rd_en is low.
  always_ff @(posedge rd_clk) begin
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/taxi_ram_arb_rr.sv
// Combinational round-robin arbiter with a registered priority pointer that
// advances past the granted port whenever update is asserted.
module taxi_ram_arb_rr
  import taxi_ram_arb_pkg::*;
#(
  parameter int unsigned PORTS = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PORTS-1:0] req,
  input  logic             update,
  output logic [PORTS-1:0] grant
);

  localparam int unsigned CL_PORTS = cl_ports(PORTS);

  logic [CL_PORTS-1:0] ptr_q, ptr_d;
  logic [MaxPorts-1:0] req_ext, grant_ext;
  logic                unused_grant_ext;

  always_comb begin
    req_ext            = '0;
    req_ext[PORTS-1:0] = req;
    grant_ext          = rr_next(req_ext, MaxPtrW'(ptr_q));
  end

  assign grant            = grant_ext[PORTS-1:0];
  assign unused_grant_ext = ^grant_ext;

  always_comb begin
    ptr_d = ptr_q;
    if (update) begin
      for (int unsigned i = 0; i < PORTS; i++) begin
        if (grant[i]) begin
          ptr_d = (i == PORTS - 1) ? '0 : CL_PORTS'(i + 1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/taxi_ram_1r1w_arb.sv
// Shares one 1R1W RAM between PORTS requesters with independent round-robin write
// and read arbitration. Define TAXI_RAM_ARB_BYPASS_EN for same-cycle write-to-read forwarding.
module taxi_ram_1r1w_arb
  import taxi_ram_arb_pkg::*;
#(
  parameter int unsigned PORTS   = 4,
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter logic        STRB_EN = 1'b1,
  parameter int unsigned STRB_W  = DATA_W / 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PORTS-1:0]        s_wr_valid,
  output logic [PORTS-1:0]        s_wr_ready,
  input  logic [PORTS*ADDR_W-1:0] s_wr_addr,
  input  logic [PORTS*DATA_W-1:0] s_wr_data,
  input  logic [PORTS*STRB_W-1:0] s_wr_strb,
  input  logic [PORTS-1:0]        s_rd_valid,
  output logic [PORTS-1:0]        s_rd_ready,
  input  logic [PORTS*ADDR_W-1:0] s_rd_addr,
  output logic [PORTS-1:0]        m_rd_resp_valid,
  input  logic [PORTS-1:0]        m_rd_resp_ready,
  output logic [DATA_W-1:0]       m_rd_resp_data
);

  logic [PORTS-1:0]  wr_grant, rd_grant;
  logic              wr_fire, rd_fire, wr_en;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic [DATA_W-1:0] wr_data, ram_rd_data;
  logic [STRB_W-1:0] wr_strb;
  logic [PORTS-1:0]  resp_valid_q, resp_valid_d;
  logic              slot_full, owner_ready, can_issue;

  taxi_ram_arb_rr #(.PORTS(PORTS)) u_wr_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (s_wr_valid),
    .update (wr_fire),
    .grant  (wr_grant)
  );

  taxi_ram_arb_rr #(.PORTS(PORTS)) u_rd_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (s_rd_valid),
    .update (rd_fire),
    .grant  (rd_grant)
  );

  // A new read may issue only if the response slot frees on this same edge.
  assign slot_full   = |resp_valid_q;
  assign owner_ready = |(resp_valid_q & m_rd_resp_ready);
  assign can_issue   = !slot_full || owner_ready;

  assign s_wr_ready = rst ? '0 : wr_grant;
  assign s_rd_ready = (rst || !can_issue) ? '0 : rd_grant;
  assign wr_fire    = |(s_wr_valid & s_wr_ready);
  assign rd_fire    = |(s_rd_valid & s_rd_ready);
  assign wr_en      = wr_fire && !rst;

  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    wr_strb = '0;
    rd_addr = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      if (wr_grant[i]) begin
        wr_addr = s_wr_addr[i*ADDR_W +: ADDR_W];
        wr_data = s_wr_data[i*DATA_W +: DATA_W];
        wr_strb = s_wr_strb[i*STRB_W +: STRB_W];
      end
      if (rd_grant[i]) begin
        rd_addr = s_rd_addr[i*ADDR_W +: ADDR_W];
      end
    end
  end

  taxi_ram_1r1w_dc #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .STRB_EN (STRB_EN),
    .STRB_W  (STRB_W)
  ) u_ram (
    .wr_clk  (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_clk  (clk),
    .rd_en   (rd_fire),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  always_comb begin
    resp_valid_d = resp_valid_q;
    if (rd_fire) begin
      resp_valid_d = s_rd_ready;
    end else if (owner_ready) begin
      resp_valid_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      resp_valid_q <= '0;
    end else begin
      resp_valid_q <= resp_valid_d;
    end
  end

  assign m_rd_resp_valid = resp_valid_q;

`ifdef TAXI_RAM_ARB_BYPASS_EN
  localparam int unsigned LaneW = DATA_W / STRB_W;

  logic              fwd_hit_q;
  logic [DATA_W-1:0] fwd_data_q;
  logic [STRB_W-1:0] fwd_strb_q;

  // Captured only on read issue so a stalled response stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
      fwd_strb_q <= '0;
    end else if (rd_fire) begin
      fwd_hit_q  <= wr_en && (wr_addr == rd_addr);
      fwd_data_q <= wr_data;
      fwd_strb_q <= STRB_EN ? wr_strb : '1;
    end
  end

  always_comb begin
    m_rd_resp_data = ram_rd_data;
    if (fwd_hit_q) begin
      for (int unsigned i = 0; i < STRB_W; i++) begin
        if (fwd_strb_q[i]) begin
          m_rd_resp_data[i*LaneW +: LaneW] = fwd_data_q[i*LaneW +: LaneW];
        end
      end
    end
  end
`else
  assign m_rd_resp_data = ram_rd_data;
`endif

endmodule

// File: tb/tb_taxi_ram_1r1w_arb.sv
// Randomised scoreboard bench for taxi_ram_1r1w_arb against a behavioural
// round-robin and memory model.
module tb_taxi_ram_1r1w_arb;

  localparam int P  = 4;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int SW = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [P-1:0]     s_wr_valid, s_wr_ready, s_rd_valid, s_rd_ready;
  logic [P-1:0]     m_rd_resp_valid, m_rd_resp_ready;
  logic [P*AW-1:0]  s_wr_addr, s_rd_addr;
  logic [P*DW-1:0]  s_wr_data;
  logic [P*SW-1:0]  s_wr_strb;
  logic [DW-1:0]    m_rd_resp_data;

  always #5 clk = ~clk;

  taxi_ram_1r1w_arb #(
    .PORTS   (P),
    .ADDR_W  (AW),
    .DATA_W  (DW),
    .STRB_EN (1'b1),
    .STRB_W  (SW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .s_wr_valid      (s_wr_valid),
    .s_wr_ready      (s_wr_ready),
    .s_wr_addr       (s_wr_addr),
    .s_wr_data       (s_wr_data),
    .s_wr_strb       (s_wr_strb),
    .s_rd_valid      (s_rd_valid),
    .s_rd_ready      (s_rd_ready),
    .s_rd_addr       (s_rd_addr),
    .m_rd_resp_valid (m_rd_resp_valid),
    .m_rd_resp_ready (m_rd_resp_ready),
    .m_rd_resp_data  (m_rd_resp_data)
  );

  typedef struct {
    logic [P-1:0]  owner;
    logic [DW-1:0] data;
  } resp_t;

  resp_t         sb[$];
  logic [DW-1:0] mem_m [0:1023];
  int            wr_ptr = 0;
  int            rd_ptr = 0;
  int            n_cmp  = 0;
  int            n_err  = 0;
  bit            mon_en = 1'b0;
  logic [P-1:0]  wr_done, rd_done;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // First valid port at or after the priority pointer, -1 when none.
  function automatic int rr_pick(input logic [P-1:0] v, input int ptr);
    for (int k = 0; k < P; k++) begin
      if (v[(ptr + k) % P]) return (ptr + k) % P;
    end
    return -1;
  endfunction

  // Monitor: compares the presented response with the scoreboard head.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() == 0) begin
        check("resp_idle", DW'(m_rd_resp_valid), '0);
      end else begin
        check("resp_owner", DW'(m_rd_resp_valid), DW'(sb[0].owner));
        check("resp_data", m_rd_resp_data, sb[0].data);
        if ((m_rd_resp_ready & sb[0].owner) != '0) void'(sb.pop_front());
      end
    end
  end

  // Reference model: runs after the monitor, predicts grants and the next state.
  always @(negedge clk) begin : model
    int            wi, ri;
    logic [P-1:0]  ew, er;
    logic [AW-1:0] wa, ra;
    logic [DW-1:0] wd, d;
    logic [SW-1:0] ws;
    #1;
    if (mon_en) begin
      wi = rst ? -1 : rr_pick(s_wr_valid, wr_ptr);
      ri = (rst || sb.size() != 0) ? -1 : rr_pick(s_rd_valid, rd_ptr);
      ew = (wi >= 0) ? P'(1) << wi : '0;
      er = (ri >= 0) ? P'(1) << ri : '0;
      check("wr_ready", DW'(s_wr_ready), DW'(ew));
      check("rd_ready", DW'(s_rd_ready), DW'(er));
      if (rst) begin
        sb.delete();
        wr_ptr = 0;
        rd_ptr = 0;
      end else begin
        wa = '0; wd = '0; ws = '0;
        if (wi >= 0) begin
          wa = s_wr_addr[wi*AW +: AW];
          wd = s_wr_data[wi*DW +: DW];
          ws = s_wr_strb[wi*SW +: SW];
        end
        if (ri >= 0) begin
          ra = s_rd_addr[ri*AW +: AW];
          d  = mem_m[ra];
`ifdef TAXI_RAM_ARB_BYPASS_EN
          if (wi >= 0 && wa == ra) begin
            for (int b = 0; b < SW; b++) if (ws[b]) d[b*8 +: 8] = wd[b*8 +: 8];
          end
`endif
          sb.push_back('{owner: er, data: d});
          rd_ptr = (ri + 1) % P;
        end
        if (wi >= 0) begin
          for (int b = 0; b < SW; b++) if (ws[b]) mem_m[wa][b*8 +: 8] = wd[b*8 +: 8];
          wr_ptr = (wi + 1) % P;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    wr_done = s_wr_valid & s_wr_ready;
    rd_done = s_rd_valid & s_rd_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int p, input int a, input logic [DW-1:0] dat, input logic [SW-1:0] st);
    s_wr_valid[p]          = 1'b1;
    s_wr_addr[p*AW +: AW]  = AW'(a);
    s_wr_data[p*DW +: DW]  = dat;
    s_wr_strb[p*SW +: SW]  = st;
  endtask

  task automatic set_rd(input int p, input int a);
    s_rd_valid[p]         = 1'b1;
    s_rd_addr[p*AW +: AW] = AW'(a);
  endtask

  // Holds requests until each is accepted, bounded by max cycles.
  task automatic run_until_idle(input int max);
    for (int c = 0; c < max; c++) begin
      if (s_wr_valid == '0 && s_rd_valid == '0) return;
      tick();
      s_wr_valid &= ~wr_done;
      s_rd_valid &= ~rd_done;
    end
    check("accept_timeout", DW'({s_wr_valid, s_rd_valid}), '0);
    s_wr_valid = '0;
    s_rd_valid = '0;
  endtask

  initial begin
    rst = 1'b1;
    s_wr_valid = '0; s_rd_valid = '0; m_rd_resp_ready = '0;
    s_wr_addr = '0; s_wr_data = '0; s_wr_strb = '0; s_rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;
    tick();
    rst = 1'b0;
    repeat (2) tick();

    // Known contents for the address window used below.
    for (int a = 0; a < 32; a++) begin
      set_wr(3, a, '0, 4'hF);
      run_until_idle(4);
    end
    m_rd_resp_ready = '1;
    set_rd(0, 0);
    run_until_idle(4);
    tick();

    for (int i = 0; i < P; i++) set_wr(i, i, DW'(32'hA0 + i), 4'hF);
    run_until_idle(12);
    for (int i = 0; i < P; i++) set_rd(i, i);
    run_until_idle(12);
    tick();

    set_wr(2, 'h20, 32'hFFFF_FFFF, 4'hF);
    run_until_idle(4);
    set_wr(2, 'h20, 32'h1122_3344, 4'b0101);
    run_until_idle(4);
    set_rd(2, 'h20);
    run_until_idle(4);
    tick();

    for (int c = 0; c < 16; c++) begin
      set_rd(1, $urandom_range(0, 31));
      set_rd(3, $urandom_range(0, 31));
      tick();
    end
    s_rd_valid = '0;
    tick();

    m_rd_resp_ready[0] = 1'b0;
    set_rd(0, 5);
    tick();
    s_rd_valid = 4'b1110;
    repeat (5) tick();
    m_rd_resp_ready = '1;
    run_until_idle(10);
    tick();

    set_wr(1, 'h10, 32'h5A5A_5A5A, 4'hF);
    set_rd(3, 'h10);
    run_until_idle(6);
    tick();

    m_rd_resp_ready = '0;
    set_rd(0, 1);
    run_until_idle(4);
    repeat (2) tick();
    rst = 1'b1;
    set_wr(0, 2, 32'hDEAD_BEEF, 4'hF);
    tick();
    rst = 1'b0;
    s_wr_valid = '0;
    m_rd_resp_ready = '1;
    set_rd(0, 2);
    run_until_idle(4);
    tick();

    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < P; i++) begin
        s_wr_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
        s_rd_addr[i*AW +: AW] = AW'($urandom_range(0, 31));
        s_wr_data[i*DW +: DW] = $urandom;
        s_wr_strb[i*SW +: SW] = SW'($urandom);
        m_rd_resp_ready[i]    = ($urandom_range(0, 3) != 0);
      end
      s_wr_valid = P'($urandom);
      s_rd_valid = P'($urandom);
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    s_wr_valid = '0;
    s_rd_valid = '0;
    m_rd_resp_ready = '1;
    repeat (4) tick();
    check("sb_drained", DW'(sb.size()), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished at %0t", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
